sld_trigger_qualifier: RTL and testbench

SLD_TRIGGER_QUALIFIER -- requirements
Module: sld_trigger_qualifier

---
 rtl/sld_trigger_qualifier.sv | 138 +++++++++++++
 tb/tb_sld_trigger_qualifier.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/sld_trigger_qualifier.sv
// Trigger qualifier for a logic-analyzer capture path; build with SLD_CHANGE_QUALIFIER_EN to store only changed samples.
// Latency: one cycle from probe_data to acq_data_in/storage_enable/acq_trigger_in.
// Backpressure: none; the downstream recorder must accept every sample flagged by storage_enable.
module sld_trigger_qualifier #(
    parameter int SLD_DATA_BITS          = 64,
    parameter int SLD_POST_TRIGGER_DEPTH = 4096
) (
    input  logic                     acq_clk,
    input  logic                     acq_rst_n,
    input  logic [SLD_DATA_BITS-1:0] probe_data,
    input  logic [SLD_DATA_BITS-1:0] trig_mask,
    input  logic [SLD_DATA_BITS-1:0] trig_value,
    input  logic                     ext_trigger,
    input  logic                     arm,
    output logic [SLD_DATA_BITS-1:0] acq_data_in,
    output logic                     acq_trigger_in,
    output logic                     storage_enable,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [15:0] POST_DEPTH = 16'(SLD_POST_TRIGGER_DEPTH);

    state_t                   state_q, state_d;
    logic [15:0]              cnt_q, cnt_d;
    logic [SLD_DATA_BITS-1:0] acq_data_in_q, acq_data_in_d;
    logic                     acq_trigger_in_q, acq_trigger_in_d;
    logic                     storage_enable_q, storage_enable_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic match;
    logic capture_window;
    logic store;

    assign match = (~|((probe_data ^ trig_value) & trig_mask)) | ext_trigger;

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        capture_window   = 1'b0;
        acq_trigger_in_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arm) state_d = S_ARMED;
            end
            S_ARMED: begin
                capture_window = 1'b1;
                if (match) begin
                    acq_trigger_in_d = 1'b1;
                    if (POST_DEPTH == 16'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_POST;
                        cnt_d   = POST_DEPTH;
                    end
                end
            end
            S_POST: begin
                capture_window = 1'b1;
                // Counter value 1 marks the final post-trigger sample; never wrap below 0.
                if (cnt_q != 16'd0) cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd1) state_d = S_DONE;
            end
            S_DONE: begin
                if (arm) state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef SLD_CHANGE_QUALIFIER_EN
    logic                     first_q, first_d;
    logic [SLD_DATA_BITS-1:0] last_q, last_d;

    // The first armed cycle and the trigger sample are always kept, even if unchanged.
    assign store = capture_window &
                   (first_q | acq_trigger_in_d | (probe_data != last_q));

    always_comb begin
        first_d = ((state_q == S_IDLE) || (state_q == S_DONE)) && arm;
        last_d  = store ? probe_data : last_q;
    end

    always_ff @(posedge acq_clk or negedge acq_rst_n) begin
        if (!acq_rst_n) begin
            first_q <= 1'b0;
            last_q  <= '0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
        end
    end
`else
    assign store = capture_window;
`endif

    always_comb begin
        acq_data_in_d    = store ? probe_data : acq_data_in_q;
        storage_enable_d = store;
        busy_d           = (state_d == S_ARMED) || (state_d == S_POST);
        done_d           = (state_d == S_DONE);
    end

    always_ff @(posedge acq_clk or negedge acq_rst_n) begin
        if (!acq_rst_n) begin
            state_q          <= S_IDLE;
            cnt_q            <= 16'd0;
            acq_data_in_q    <= '0;
            acq_trigger_in_q <= 1'b0;
            storage_enable_q <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            acq_data_in_q    <= acq_data_in_d;
            acq_trigger_in_q <= acq_trigger_in_d;
            storage_enable_q <= storage_enable_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
        end
    end

    assign acq_data_in    = acq_data_in_q;
    assign acq_trigger_in = acq_trigger_in_q;
    assign storage_enable = storage_enable_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sld_trigger_qualifier.sv
// Directed bench: a depth-8 instance and a depth-0 instance sharing clock, reset and probe inputs.
module tb_sld_trigger_qualifier;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] probe = '0;
    logic [W-1:0] mask  = '0;
    logic [W-1:0] value = '0;
    logic         ext   = 1'b0;
    logic         arm8  = 1'b0;
    logic         arm0  = 1'b0;

    logic [W-1:0] d8, d0;
    logic         t8, se8, b8, dn8;
    logic         t0, se0, b0, dn0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sld_trigger_qualifier #(.SLD_DATA_BITS(W), .SLD_POST_TRIGGER_DEPTH(8)) dut8 (
        .acq_clk(clk), .acq_rst_n(rst_n), .probe_data(probe), .trig_mask(mask),
        .trig_value(value), .ext_trigger(ext), .arm(arm8), .acq_data_in(d8),
        .acq_trigger_in(t8), .storage_enable(se8), .busy(b8), .done(dn8)
    );

    sld_trigger_qualifier #(.SLD_DATA_BITS(W), .SLD_POST_TRIGGER_DEPTH(0)) dut0 (
        .acq_clk(clk), .acq_rst_n(rst_n), .probe_data(probe), .trig_mask(mask),
        .trig_value(value), .ext_trigger(ext), .arm(arm0), .acq_data_in(d0),
        .acq_trigger_in(t0), .storage_enable(se0), .busy(b0), .done(dn0)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_data8", 64'(d8), 64'h0);
        check("rst_se8", 64'(se8), 64'h0);
        check("rst_trig8", 64'(t8), 64'h0);
        check("rst_busy8", 64'(b8), 64'h0);
        check("rst_done8", 64'(dn8), 64'h0);
        check("rst_done0", 64'(dn0), 64'h0);
        rst_n = 1'b1;
        tick();
        check("idle_se8", 64'(se8), 64'h0);
        check("idle_busy8", 64'(b8), 64'h0);

        // Mask 0xFF / value 0x5A, incrementing probe
        mask  = 8'hFF;
        value = 8'h5A;
        arm8  = 1'b1;
        tick();
        arm8 = 1'b0;
        check("arm_busy8", 64'(b8), 64'h1);
        check("arm_se8", 64'(se8), 64'h0);
        check("arm_done8", 64'(dn8), 64'h0);
        for (int p = 0; p <= 8'h5A; p++) begin
            probe = 8'(p);
            tick();
            check("armed_se8", 64'(se8), 64'h1);
            check("armed_data8", 64'(d8), 64'(p));
            check("armed_trig8", 64'(t8), (p == 8'h5A) ? 64'h1 : 64'h0);
            check("armed_busy8", 64'(b8), 64'h1);
        end
        // Eight post samples; an arm pulse mid-capture must not reload the counter
        for (int k = 1; k <= 8; k++) begin
            probe = 8'(8'h5A + k);
            arm8  = (k == 3);
            tick();
            arm8 = 1'b0;
            check("post_se8", 64'(se8), 64'h1);
            check("post_trig8", 64'(t8), 64'h0);
            check("post_data8", 64'(d8), 64'(8'h5A + k));
            check("post_done8", 64'(dn8), (k == 8) ? 64'h1 : 64'h0);
            check("post_busy8", 64'(b8), (k == 8) ? 64'h0 : 64'h1);
        end
        probe = 8'h5A;
        tick();
        check("done_se8", 64'(se8), 64'h0);
        check("done_done8", 64'(dn8), 64'h1);
        check("done_hold8", 64'(d8), 64'h62);
        check("done_trig8", 64'(t8), 64'h0);

        // Re-arm from DONE
        arm8 = 1'b1;
        tick();
        arm8 = 1'b0;
        check("rearm_busy8", 64'(b8), 64'h1);
        check("rearm_done8", 64'(dn8), 64'h0);
        check("rearm_se8", 64'(se8), 64'h0);
        tick();
        check("retrig_trig8", 64'(t8), 64'h1);
        check("retrig_se8", 64'(se8), 64'h1);
        check("retrig_data8", 64'(d8), 64'h5A);

        // Reset while the post counter holds 3
        probe = 8'h00;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pre_rst_se8", 64'(se8), 64'h1);
        end
        rst_n = 1'b0;
        #1;
        check("async_se8", 64'(se8), 64'h0);
        check("async_busy8", 64'(b8), 64'h0);
        check("async_data8", 64'(d8), 64'h0);
        check("async_trig8", 64'(t8), 64'h0);
        tick();
        rst_n = 1'b1;
        probe = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("post_rst_se8", 64'(se8), 64'h0);
            check("post_rst_busy8", 64'(b8), 64'h0);
            check("post_rst_done8", 64'(dn8), 64'h0);
        end

        // Depth 0 with an external trigger
        probe = 8'h00;
        arm0  = 1'b1;
        tick();
        arm0 = 1'b0;
        check("d0_arm_busy", 64'(b0), 64'h1);
        check("d0_arm_se", 64'(se0), 64'h0);
        probe = 8'h33;
        ext   = 1'b1;
        tick();
        ext = 1'b0;
        check("d0_trig_se", 64'(se0), 64'h1);
        check("d0_trig", 64'(t0), 64'h1);
        check("d0_trig_data", 64'(d0), 64'h33);
        tick();
        check("d0_after_se", 64'(se0), 64'h0);
        check("d0_after_done", 64'(dn0), 64'h1);
        check("d0_after_busy", 64'(b0), 64'h0);
        check("d0_after_trig", 64'(t0), 64'h0);

`ifdef SLD_CHANGE_QUALIFIER_EN
        // Change qualifier: only the first sample and the change are stored
        mask = 8'h00;
        arm8 = 1'b1;
        tick();
        arm8  = 1'b0;
        probe = 8'h11;
        tick();
        check("cq_first_se", 64'(se8), 64'h1);
        check("cq_first_trig", 64'(t8), 64'h1);
        check("cq_first_data", 64'(d8), 64'h11);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cq_hold_se", 64'(se8), 64'h0);
        end
        probe = 8'h22;
        tick();
        check("cq_change_se", 64'(se8), 64'h1);
        check("cq_change_data", 64'(d8), 64'h22);
        check("cq_change_trig", 64'(t8), 64'h0);
        tick();
        check("cq_same_se", 64'(se8), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
